// File: rtl/adat_frame_sched.sv
// adat_frame_sched
// Frame scheduler for the ADAT lightpipe framer. A single producer loads channel
// samples into a back buffer over valid/ready. Once per frame the back buffer is
// swapped into the word outputs. Wordclock is derived from mclk. Channels that were
// not refreshed during a frame raise a sticky underrun flag.
//
// Frame timing (cnt is the free-running divider):
//   cnt == 2**DIV_LOG2-2 : last cycle in which a sample can land for this frame
//   cnt == 2**DIV_LOG2-1 : SWAP cycle, producer is stalled
//   cnt == 0             : new words and user bits visible, frame_strobe high
// The words and user bits change at cnt == 0. At that point wordclock is low, so
// the framer sees them stable for half a frame before the next wordclock rise.

module adat_frame_sched #(
    parameter int CHANNELS      = 8,
    parameter int WIDTH         = 24,
    parameter int DIV_LOG2      = 8,
    parameter int UNDERRUN_MUTE = 1
) (
    input  logic                      mclk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [2:0]                s_chan,
    input  logic [WIDTH-1:0]          s_data,
    input  logic [3:0]                user_in,
    input  logic                      underrun_clr,
    output logic                      wordclock,
    output logic [CHANNELS*WIDTH-1:0] words,
    output logic [3:0]                user,
    output logic                      frame_strobe,
    output logic [CHANNELS-1:0]       underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2
    } state_t;

    // The count value one cycle before the swap: all ones except the LSB.
    localparam logic [DIV_LOG2-1:0] CNT_PRE_SWAP = {{(DIV_LOG2-1){1'b1}}, 1'b0};

    state_t                         state;
    logic   [DIV_LOG2-1:0]          cnt;
    logic                           accept;
    logic   [CHANNELS-1:0][WIDTH-1:0] back;
    logic   [CHANNELS-1:0]          fill;
    logic   [CHANNELS-1:0]          swap_set;

    assign accept    = s_valid && s_ready;
    assign wordclock = cnt[DIV_LOG2-1];

    // Flags that a swap raises: any channel with no refresh during the frame that is ending.
    always_comb begin
        swap_set = '0;
        if (state == SWAP) begin
            swap_set = ~fill;
        end
    end

    // Free-running frame divider. Its MSB is wordclock, so the clock is a clean register bit.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame FSM. It idles until the first sample arrives, then swaps once per frame. s_ready is registered from the next state.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            s_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (cnt == CNT_PRE_SWAP) begin
                        state   <= SWAP;
                        s_ready <= 1'b0;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                SWAP: begin
                    state   <= FILL;
                    s_ready <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

    // Back-buffer loading, plus the end-of-frame swap into words and user. The back buffer survives the swap; only the fill mask clears.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            back         <= '0;
            fill         <= '0;
            words        <= '0;
            user         <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= (state == SWAP);
            if (state == SWAP) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (fill[n]) begin
                        words[n*WIDTH +: WIDTH] <= back[n];
                    end else if (UNDERRUN_MUTE != 0) begin
                        words[n*WIDTH +: WIDTH] <= '0;
                    end
                end
                user <= user_in;
                fill <= '0;
            end else if (accept) begin
                // Channel indices with no matching lane are accepted and simply discarded.
                for (int n = 0; n < CHANNELS; n++) begin
                    if (s_chan == 3'(n)) begin
                        back[n] <= s_data;
                        fill[n] <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky underrun flags. A flag raised by the swap takes priority over a simultaneous clear.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            underrun <= '0;
        end else begin
            underrun <= (underrun_clr ? '0 : underrun) | swap_set;
        end
    end

endmodule

// File: tb/tb_adat_frame_sched.sv
// tb_adat_frame_sched
// Two scheduler instances are driven by the same producer: dut_a has 8 channels and
// mutes on underrun; dut_b has 6 channels and holds its words on underrun. A
// frame-level reference model inside the bench predicts both instances.

module tb_adat_frame_sched;

    localparam int FR = 256;

    logic         mclk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic [2:0]   s_chan = '0;
    logic [23:0]  s_data = '0;
    logic [3:0]   user_in = '0;
    logic         underrun_clr = 1'b0;

    logic         s_ready_a, s_ready_b, wordclock_a, wordclock_b;
    logic         strobe_a, strobe_b;
    logic [191:0] words_a;
    logic [143:0] words_b;
    logic [3:0]   user_a, user_b;
    logic [7:0]   underrun_a;
    logic [5:0]   underrun_b;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int          cyc_m;
    bit          started_m;
    bit          ready_m;
    bit          strobe_m;
    logic [23:0] back_m  [2][8];
    bit          fill_m  [2][8];
    logic [23:0] words_m [2][8];
    logic [7:0]  ur_m    [2];
    logic [3:0]  user_m;

    adat_frame_sched #(.CHANNELS(8), .WIDTH(24), .DIV_LOG2(8), .UNDERRUN_MUTE(1)) dut_a (
        .mclk(mclk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_chan(s_chan),
        .s_data(s_data), .user_in(user_in), .underrun_clr(underrun_clr),
        .wordclock(wordclock_a), .words(words_a), .user(user_a),
        .frame_strobe(strobe_a), .underrun(underrun_a));

    adat_frame_sched #(.CHANNELS(6), .WIDTH(24), .DIV_LOG2(8), .UNDERRUN_MUTE(0)) dut_b (
        .mclk(mclk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_chan(s_chan),
        .s_data(s_data), .user_in(user_in), .underrun_clr(underrun_clr),
        .wordclock(wordclock_b), .words(words_b), .user(user_b),
        .frame_strobe(strobe_b), .underrun(underrun_b));

    always #5 mclk = ~mclk;

    function automatic int chn(input int i);
        return (i == 0) ? 8 : 6;
    endfunction

    function automatic bit mute(input int i);
        return (i == 0);
    endfunction

    function automatic logic [191:0] exp_words_a();
        logic [191:0] v;
        v = '0;
        for (int n = 0; n < 8; n++) v[n*24 +: 24] = words_m[0][n];
        return v;
    endfunction

    function automatic logic [143:0] exp_words_b();
        logic [143:0] v;
        v = '0;
        for (int n = 0; n < 6; n++) v[n*24 +: 24] = words_m[1][n];
        return v;
    endfunction

    task automatic model_reset();
        cyc_m = 0;
        started_m = 0;
        ready_m = 0;
        strobe_m = 0;
        user_m = '0;
        for (int i = 0; i < 2; i++) begin
            ur_m[i] = '0;
            for (int n = 0; n < 8; n++) begin
                back_m[i][n] = '0;
                fill_m[i][n] = 0;
                words_m[i][n] = '0;
            end
        end
    endtask

    // Predicts the effect of one rising mclk edge from the current inputs.
    task automatic model_edge();
        int c;
        logic [7:0] setv;
        c = cyc_m % FR;
        if (started_m && c == FR - 1) begin
            for (int i = 0; i < 2; i++) begin
                setv = '0;
                for (int n = 0; n < chn(i); n++) begin
                    if (fill_m[i][n]) begin
                        words_m[i][n] = back_m[i][n];
                    end else begin
                        setv[n] = 1'b1;
                        if (mute(i)) words_m[i][n] = '0;
                    end
                    fill_m[i][n] = 0;
                end
                ur_m[i] = (underrun_clr ? 8'h00 : ur_m[i]) | setv;
            end
            user_m = user_in;
            strobe_m = 1;
        end else begin
            strobe_m = 0;
            if (underrun_clr) begin
                ur_m[0] = '0;
                ur_m[1] = '0;
            end
            if (s_valid && ready_m) begin
                for (int i = 0; i < 2; i++) begin
                    if (int'(s_chan) < chn(i)) begin
                        back_m[i][s_chan] = s_data;
                        fill_m[i][s_chan] = 1;
                    end
                end
                started_m = 1;
            end
        end
        cyc_m++;
        ready_m = started_m ? ((cyc_m % FR) != FR - 1) : 1'b1;
    endtask

    task automatic step();
        model_edge();
        @(posedge mclk);
        #1;
    endtask

    task automatic run_to(input int c);
        int k;
        k = 0;
        while ((cyc_m % FR) != c && k < 2 * FR) begin
            step();
            k++;
        end
    endtask

    task automatic write_sample(input logic [2:0] ch, input logic [23:0] d);
        int waited;
        bit done;
        waited = 0;
        done = 0;
        s_valid = 1'b1;
        s_chan = ch;
        s_data = d;
        while (!done && waited < 600) begin
            done = ready_m;
            step();
            waited++;
        end
        s_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL write_timeout got=no_accept expected=accept ch=%0d", ch);
        end
    endtask

    task automatic test_reset();
        int high_cnt, rises, last_rise, period;
        logic prev_wc;
        $display("[TB] test_reset");
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        vectors++; if (words_a !== '0) begin miscompares++; $display("[TB] FAIL rst_words_a got=%h expected=0", words_a); end
        vectors++; if (s_ready_a !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready got=%b expected=0", s_ready_a); end
        vectors++; if (underrun_a !== 8'h00 || underrun_b !== 6'h00) begin miscompares++; $display("[TB] FAIL rst_underrun got=%h/%h expected=0", underrun_a, underrun_b); end
        vectors++; if (wordclock_a !== 1'b0 || strobe_a !== 1'b0 || user_a !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_misc got=%b%b%h expected=000", wordclock_a, strobe_a, user_a); end
        @(posedge mclk);
        @(posedge mclk);
        #1;
        rst = 1'b0;
        model_reset();
        high_cnt = 0; rises = 0; last_rise = 0; period = 0;
        prev_wc = wordclock_a;
        for (int k = 0; k < 3 * FR; k++) begin
            step();
            vectors++;
            if (words_a !== '0 || words_b !== '0 || underrun_a !== 8'h00 || strobe_a !== 1'b0 || strobe_b !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_outputs got=%h/%h/%b expected=0/0/0 cyc=%0d", words_a, underrun_a, strobe_a, cyc_m);
            end
            vectors++;
            if (wordclock_a !== ((cyc_m % FR) >= FR / 2) || s_ready_a !== ready_m) begin
                miscompares++;
                $display("[TB] FAIL idle_wc_ready got=%b%b expected=%b%b cyc=%0d", wordclock_a, s_ready_a, (cyc_m % FR) >= FR / 2, ready_m, cyc_m);
            end
            if (wordclock_a === 1'b1) high_cnt++;
            if (prev_wc === 1'b0 && wordclock_a === 1'b1) begin
                if (rises > 0) period = cyc_m - last_rise;
                last_rise = cyc_m;
                rises++;
            end
            prev_wc = wordclock_a;
        end
        vectors++; if (high_cnt != 3 * FR / 2) begin miscompares++; $display("[TB] FAIL wc_duty got=%0d expected=%0d", high_cnt, 3 * FR / 2); end
        vectors++; if (rises != 3 || period != FR) begin miscompares++; $display("[TB] FAIL wc_period got=%0d/%0d expected=3/%0d", rises, period, FR); end
    endtask

    task automatic test_pattern();
        int sa, sb;
        $display("[TB] test_pattern");
        user_in = 4'hA;
        for (int n = 0; n < 8; n++) write_sample(3'(n), (n % 2 == 0) ? 24'hFFFFFF : 24'h000000);
        sa = 0; sb = 0;
        do begin
            step();
            if (strobe_a === 1'b1) sa++;
            if (strobe_b === 1'b1) sb++;
        end while ((cyc_m % FR) != 0);
        vectors++; if (words_a !== exp_words_a() || words_a !== {4{48'h000000FFFFFF}}) begin miscompares++; $display("[TB] FAIL pat_words_a got=%h expected=%h", words_a, exp_words_a()); end
        vectors++; if (words_b !== exp_words_b()) begin miscompares++; $display("[TB] FAIL pat_words_b got=%h expected=%h", words_b, exp_words_b()); end
        vectors++; if (strobe_a !== 1'b1 || sa != 1 || sb != 1) begin miscompares++; $display("[TB] FAIL pat_strobe got=%b/%0d/%0d expected=1/1/1", strobe_a, sa, sb); end
        vectors++; if (underrun_a !== 8'h00 || underrun_b !== 6'h00) begin miscompares++; $display("[TB] FAIL pat_underrun got=%h/%h expected=00/00", underrun_a, underrun_b); end
        vectors++; if (user_a !== 4'hA || user_b !== 4'hA) begin miscompares++; $display("[TB] FAIL pat_user got=%h/%h expected=a", user_a, user_b); end
    endtask

    task automatic test_partial();
        $display("[TB] test_partial");
        write_sample(3'd0, 24'h123456);
        run_to(0);
        vectors++; if (words_a !== {168'h0, 24'h123456}) begin miscompares++; $display("[TB] FAIL part_words_mute got=%h expected=%h", words_a, {168'h0, 24'h123456}); end
        vectors++; if (underrun_a !== 8'hFE) begin miscompares++; $display("[TB] FAIL part_underrun_a got=%h expected=fe", underrun_a); end
        vectors++; if (words_b !== {24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'h123456}) begin miscompares++; $display("[TB] FAIL part_words_hold got=%h", words_b); end
        vectors++; if (underrun_b !== 6'h3E) begin miscompares++; $display("[TB] FAIL part_underrun_b got=%h expected=3e", underrun_b); end
    endtask

    task automatic test_hold_swap();
        bit acc;
        $display("[TB] test_hold_swap");
        run_to(FR - 1);
        s_valid = 1'b1; s_chan = 3'd7; s_data = 24'h7E57AB;
        vectors++; if (s_ready_a !== 1'b0 || s_ready_b !== 1'b0) begin miscompares++; $display("[TB] FAIL swap_ready got=%b%b expected=00", s_ready_a, s_ready_b); end
        acc = ready_m;
        step();
        if (acc) s_valid = 1'b0;
        vectors++; if (s_ready_a !== 1'b1 || words_a[7*24 +: 24] !== 24'h0) begin miscompares++; $display("[TB] FAIL hold_cnt0 got=%b/%h expected=1/000000", s_ready_a, words_a[7*24 +: 24]); end
        acc = ready_m;
        step();
        if (acc) s_valid = 1'b0;
        run_to(0);
        vectors++; if (words_a[7*24 +: 24] !== 24'h7E57AB || words_a !== exp_words_a()) begin miscompares++; $display("[TB] FAIL hold_word7 got=%h expected=%h", words_a, exp_words_a()); end
        vectors++; if (words_b !== exp_words_b() || underrun_b !== 6'h3F) begin miscompares++; $display("[TB] FAIL drop_ch7 got=%h/%h expected=%h/3f", words_b, underrun_b, exp_words_b()); end
        vectors++; if (underrun_a !== ur_m[0]) begin miscompares++; $display("[TB] FAIL hold_underrun_a got=%h expected=%h", underrun_a, ur_m[0]); end
    endtask

    task automatic test_clr_collision();
        $display("[TB] test_clr_collision");
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        vectors++; if (underrun_a !== 8'h00 || underrun_b !== 6'h00) begin miscompares++; $display("[TB] FAIL clr_first got=%h/%h expected=00/00", underrun_a, underrun_b); end
        for (int n = 0; n < 8; n++) if (n != 3) write_sample(3'(n), 24'($urandom));
        run_to(FR - 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        vectors++; if (underrun_a !== 8'h08 || underrun_b !== 6'h08) begin miscompares++; $display("[TB] FAIL clr_vs_set got=%h/%h expected=08/08", underrun_a, underrun_b); end
        run_to(20);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        vectors++; if (underrun_a !== 8'h00 || underrun_b !== 6'h00) begin miscompares++; $display("[TB] FAIL clr_alone got=%h/%h expected=00/00", underrun_a, underrun_b); end
    endtask

    task automatic test_reset_mid();
        int sa;
        $display("[TB] test_reset_mid");
        run_to(100);
        rst = 1'b1;
        #2;
        vectors++; if (words_a !== '0 || words_b !== '0 || user_a !== 4'h0) begin miscompares++; $display("[TB] FAIL mid_rst_words got=%h/%h/%h expected=0", words_a, words_b, user_a); end
        vectors++; if (s_ready_a !== 1'b0 || wordclock_a !== 1'b0 || strobe_a !== 1'b0 || underrun_a !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_rst_ctrl got=%b%b%b/%h expected=000/00", s_ready_a, wordclock_a, strobe_a, underrun_a); end
        @(posedge mclk);
        #1;
        rst = 1'b0;
        model_reset();
        sa = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (strobe_a === 1'b1 || strobe_b === 1'b1) sa++;
        end
        vectors++; if (sa != 0 || words_a !== '0) begin miscompares++; $display("[TB] FAIL mid_idle got=%0d/%h expected=0/0", sa, words_a); end
        write_sample(3'd2, 24'hABCDEF);
        run_to(0);
        vectors++; if (words_a !== {120'h0, 24'hABCDEF, 48'h0} || strobe_a !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_words got=%h/%b", words_a, strobe_a); end
        vectors++; if (underrun_a !== 8'hFB || underrun_b !== 6'h3B) begin miscompares++; $display("[TB] FAIL restart_underrun got=%h/%h expected=fb/3b", underrun_a, underrun_b); end
    endtask

    task automatic test_random();
        bit acc;
        $display("[TB] test_random");
        for (int k = 0; k < 6 * FR; k++) begin
            if (!s_valid && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b1;
                s_chan = 3'($urandom_range(0, 7));
                s_data = 24'($urandom);
            end
            user_in = 4'($urandom);
            underrun_clr = ($urandom_range(0, 39) == 0);
            acc = s_valid && ready_m;
            step();
            if (acc) s_valid = 1'b0;
            vectors++;
            if (words_a !== exp_words_a() || words_b !== exp_words_b()) begin
                miscompares++;
                $display("[TB] FAIL rnd_words cyc=%0d got=%h/%h expected=%h/%h", cyc_m, words_a, words_b, exp_words_a(), exp_words_b());
            end
            vectors++;
            if (underrun_a !== ur_m[0] || underrun_b !== ur_m[1][5:0]) begin
                miscompares++;
                $display("[TB] FAIL rnd_underrun cyc=%0d got=%h/%h expected=%h/%h", cyc_m, underrun_a, underrun_b, ur_m[0], ur_m[1][5:0]);
            end
            vectors++;
            if (user_a !== user_m || user_b !== user_m || strobe_a !== strobe_m || strobe_b !== strobe_m) begin
                miscompares++;
                $display("[TB] FAIL rnd_user_strobe cyc=%0d got=%h%b expected=%h%b", cyc_m, user_a, strobe_a, user_m, strobe_m);
            end
            vectors++;
            if (s_ready_a !== ready_m || s_ready_b !== ready_m || wordclock_a !== ((cyc_m % FR) >= FR / 2) || wordclock_b !== wordclock_a) begin
                miscompares++;
                $display("[TB] FAIL rnd_ready_wc cyc=%0d got=%b%b expected=%b%b", cyc_m, s_ready_a, wordclock_a, ready_m, (cyc_m % FR) >= FR / 2);
            end
        end
        s_valid = 1'b0;
        underrun_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pattern();
        test_partial();
        test_hold_swap();
        test_clr_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
